ecp5pll_phase_ctrl: RTL and testbench

//  Sequencer for the dynamic phase port of the ecp5pll wrapper (dynamic_en=1).

---
 rtl/ecp5pll_pkg.sv | 34 +++
 rtl/ecp5pll_sync2.sv | 26 ++
 rtl/ecp5pll_phase_ctrl.sv | 161 ++++++++++++++++
 tb/tb_ecp5pll_phase_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecp5pll_pkg.sv
// Shared types and helpers for the ecp5pll dynamic phase sequencer.
package ecp5pll_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStepHi,
        StStepGap,
        StDone,
        StAbort
    } phase_state_e;

    localparam logic [1:0] OUT_CLKOP  = 2'd0;
    localparam logic [1:0] OUT_CLKOS  = 2'd1;
    localparam logic [1:0] OUT_CLKOS2 = 2'd2;
    localparam logic [1:0] OUT_CLKOS3 = 2'd3;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // One fine step of a phase position modulo wrap; dir=1 steps backwards.
    function automatic int unsigned pos_next(input int unsigned p, input logic dir,
                                             input int unsigned wrap);
        if (!dir) begin
            return (p >= wrap - 1) ? 0 : p + 1;
        end
        return (p == 0) ? wrap - 1 : p - 1;
    endfunction

endpackage

// File: rtl/ecp5pll_sync2.sv
// Two-flop synchroniser with asynchronous clear, for PLL-domain status bits.
module ecp5pll_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/ecp5pll_phase_ctrl.sv
// Sequencer driving the ECP5 PLL dynamic phase port (phasesel/phasedir/phasestep).
// Define ECP5PLL_PHASE_TRACK_EN to keep per-output phase position counters on pos.
module ecp5pll_phase_ctrl
    import ecp5pll_pkg::*;
#(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned STEP_HI_CYC  = 2,
    parameter int unsigned STEP_GAP_CYC = 4,
    parameter int unsigned POS_W        = 10,
    parameter int unsigned WRAP0        = 8,
    parameter int unsigned WRAP1        = 8,
    parameter int unsigned WRAP2        = 8,
    parameter int unsigned WRAP3        = 8
) (
    input  logic               clk_i,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_sel,
    input  logic               req_dir,
    input  logic [CNT_W-1:0]   req_count,
    output logic               done,
    output logic               err,
    output logic               busy,
    input  logic               pll_locked,
    output logic [1:0]         phasesel,
    output logic               phasedir,
    output logic               phasestep,
    output logic               phaseloadreg,
    output logic [4*POS_W-1:0] pos
);

    localparam int unsigned CYC_MAX = max3(SETUP_CYC, STEP_HI_CYC, STEP_GAP_CYC);
    localparam int unsigned CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

    localparam logic [CYC_W-1:0] SETUP_LD = CYC_W'(SETUP_CYC - 1);
    localparam logic [CYC_W-1:0] HI_LD    = CYC_W'(STEP_HI_CYC - 1);
    localparam logic [CYC_W-1:0] GAP_LD   = CYC_W'(STEP_GAP_CYC - 1);

    phase_state_e     state_q;
    logic [CYC_W-1:0] cyc_q;
    logic [CNT_W-1:0] remain_q;
    logic [1:0]       phasesel_q;
    logic             phasedir_q;
    logic             phasestep_q;
    logic             done_q;
    logic             err_q;
    logic             busy_q;
    logic             lk;

    ecp5pll_sync2 #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk_i(clk_i),
        .reset(reset),
        .d    (pll_locked),
        .q    (lk)
    );

    assign req_ready = (state_q == StIdle) && lk;

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cyc_q       <= '0;
            remain_q    <= '0;
            phasesel_q  <= '0;
            phasedir_q  <= 1'b0;
            phasestep_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        phasesel_q <= req_sel;
                        phasedir_q <= req_dir;
                        remain_q   <= req_count;
                        busy_q     <= 1'b1;
                        err_q      <= 1'b0;
                        if (req_count == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StSetup;
                            cyc_q   <= SETUP_LD;
                        end
                    end
                end
                StSetup, StStepHi, StStepGap: begin
                    if (!lk) begin
                        // Lock lost: cut any pulse and report; leftover steps are dropped.
                        state_q     <= StAbort;
                        phasestep_q <= 1'b0;
                        done_q      <= 1'b1;
                        err_q       <= 1'b1;
                        remain_q    <= '0;
                    end else if (cyc_q != '0) begin
                        cyc_q <= cyc_q - CYC_W'(1);
                    end else if (state_q == StStepHi) begin
                        state_q     <= StStepGap;
                        phasestep_q <= 1'b0;
                        remain_q    <= remain_q - CNT_W'(1);
                        cyc_q       <= GAP_LD;
                    end else if (state_q == StSetup || remain_q != '0) begin
                        state_q     <= StStepHi;
                        phasestep_q <= 1'b1;
                        cyc_q       <= HI_LD;
                    end else begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone, StAbort: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign phasesel     = phasesel_q;
    assign phasedir     = phasedir_q;
    assign phasestep    = phasestep_q;
    assign phaseloadreg = 1'b0;
    assign done         = done_q;
    assign err          = err_q;
    assign busy         = busy_q;

`ifdef ECP5PLL_PHASE_TRACK_EN
    // Position moves only on a completed pulse, i.e. the normal falling edge of phasestep.
    logic step_fall;
    assign step_fall = (state_q == StStepHi) && lk && (cyc_q == '0);

    for (genvar n = 0; n < 4; n++) begin : g_pos
        localparam int unsigned WRAP = (n == 0) ? WRAP0 :
                                       (n == 1) ? WRAP1 :
                                       (n == 2) ? WRAP2 : WRAP3;
        logic [POS_W-1:0] pos_q;

        always_ff @(posedge clk_i or posedge reset) begin
            if (reset) begin
                pos_q <= '0;
            end else if (step_fall && (phasesel_q == 2'(n))) begin
                pos_q <= POS_W'(pos_next(32'(pos_q), phasedir_q, WRAP));
            end
        end

        assign pos[POS_W*n +: POS_W] = pos_q;
    end
`else
    assign pos = '0;
`endif

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// Directed bench for ecp5pll_phase_ctrl; position checks follow ECP5PLL_PHASE_TRACK_EN.
module tb_ecp5pll_phase_ctrl;

    localparam int POS_W = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_sel;
    logic             req_dir;
    logic [7:0]       req_count;
    logic             done;
    logic             err;
    logic             busy;
    logic             pll_locked;
    logic [1:0]       phasesel;
    logic             phasedir;
    logic             phasestep;
    logic             phaseloadreg;
    logic [4*POS_W-1:0] pos;

    int vectors    = 0;
    int miscompares = 0;
    int exp_pos [4] = '{0, 0, 0, 0};

    ecp5pll_phase_ctrl dut (
        .clk_i       (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_sel     (req_sel),
        .req_dir     (req_dir),
        .req_count   (req_count),
        .done        (done),
        .err         (err),
        .busy        (busy),
        .pll_locked  (pll_locked),
        .phasesel    (phasesel),
        .phasedir    (phasedir),
        .phasestep   (phasestep),
        .phaseloadreg(phaseloadreg),
        .pos         (pos)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [POS_W-1:0] pos_exp(input int n);
`ifdef ECP5PLL_PHASE_TRACK_EN
        return POS_W'(exp_pos[n]);
`else
        return '0;
`endif
    endfunction

    // Accepts one request and runs it to done; lat is cycles from accept to done (-1 = none).
    task automatic do_request(input logic [1:0] sel, input logic dir, input logic [7:0] cnt,
                              output int lat, output int pulses);
        int w;
        logic prev;
        lat = -1;
        pulses = 0;
        w = 0;
        while (!req_ready && w < 50) begin
            tick();
            w++;
        end
        req_sel = sel;
        req_dir = dir;
        req_count = cnt;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        prev = 1'b0;
        for (int k = 1; k <= 2000; k++) begin
            if (phasestep && !prev) pulses++;
            prev = phasestep;
            if (done) begin
                lat = k;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        req_sel = 2'd0;
        req_dir = 1'b0;
        req_count = 8'd0;
        pll_locked = 1'b0;
        tick();
        tick();
        vectors++;
        if ({req_ready, done, err, busy, phasesel, phasedir, phasestep, phaseloadreg} !== 9'b0)
            begin
            $display("FAIL reset_outputs: got %b want 0",
                     {req_ready, done, err, busy, phasesel, phasedir, phasestep, phaseloadreg});
            miscompares++;
        end
        vectors++;
        if (pos !== '0) begin
            $display("FAIL reset_pos: got %h want 0", pos);
            miscompares++;
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_lock_handshake();
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (req_ready !== 1'b0) begin
                $display("FAIL unlocked_ready: cycle %0d got %b want 0", k, req_ready);
                miscompares++;
            end
            tick();
        end
        pll_locked = 1'b1;
        tick();
        vectors++;
        if (req_ready !== 1'b0) begin
            $display("FAIL lock_ready_1cyc: got %b want 0", req_ready);
            miscompares++;
        end
        tick();
        vectors++;
        if (req_ready !== 1'b1) begin
            $display("FAIL lock_ready_2cyc: got %b want 1", req_ready);
            miscompares++;
        end
    endtask

    // sel=2, dir=0, count=3: rises at offsets 3, 9, 15; done at 3 + 6*3 = 21.
    task automatic test_basic_sequence();
        logic exp_step;
        req_sel = 2'd2;
        req_dir = 1'b0;
        req_count = 8'd3;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            exp_step = (k == 3 || k == 4 || k == 9 || k == 10 || k == 15 || k == 16);
            vectors++;
            if (phasestep !== exp_step) begin
                $display("FAIL basic_step: offset %0d got %b want %b", k, phasestep, exp_step);
                miscompares++;
            end
            vectors++;
            if (done !== (k == 21)) begin
                $display("FAIL basic_done: offset %0d got %b want %b", k, done, k == 21);
                miscompares++;
            end
            vectors++;
            if (busy !== (k <= 21)) begin
                $display("FAIL basic_busy: offset %0d got %b want %b", k, busy, k <= 21);
                miscompares++;
            end
            vectors++;
            if (phasesel !== 2'd2 || phasedir !== 1'b0) begin
                $display("FAIL basic_sel_dir: offset %0d got %0d/%b want 2/0", k, phasesel,
                         phasedir);
                miscompares++;
            end
            if (k < 22) tick();
        end
        vectors++;
        if (req_ready !== 1'b1 || err !== 1'b0) begin
            $display("FAIL basic_after: ready/err got %b/%b want 1/0", req_ready, err);
            miscompares++;
        end
        exp_pos[2] = 3;
        vectors++;
        if (pos[POS_W*2 +: POS_W] !== pos_exp(2)) begin
            $display("FAIL basic_pos2: got %0d want %0d", pos[POS_W*2 +: POS_W], pos_exp(2));
            miscompares++;
        end
    endtask

    task automatic test_wrap();
        int lat;
        int pulses;
        do_request(2'd1, 1'b1, 8'd1, lat, pulses);
        exp_pos[1] = 7;
        vectors++;
        if (lat !== 9 || pulses !== 1) begin
            $display("FAIL wrap_down_timing: lat/pulses got %0d/%0d want 9/1", lat, pulses);
            miscompares++;
        end
        vectors++;
        if (pos[POS_W*1 +: POS_W] !== pos_exp(1)) begin
            $display("FAIL wrap_down_pos1: got %0d want %0d", pos[POS_W +: POS_W], pos_exp(1));
            miscompares++;
        end
        do_request(2'd1, 1'b0, 8'd9, lat, pulses);
        exp_pos[1] = 0;
        vectors++;
        if (lat !== 57 || pulses !== 9) begin
            $display("FAIL wrap_up_timing: lat/pulses got %0d/%0d want 57/9", lat, pulses);
            miscompares++;
        end
        vectors++;
        if (pos[POS_W*1 +: POS_W] !== pos_exp(1)) begin
            $display("FAIL wrap_up_pos1: got %0d want %0d", pos[POS_W +: POS_W], pos_exp(1));
            miscompares++;
        end
    endtask

    task automatic test_zero_count();
        int lat;
        int pulses;
        do_request(2'd2, 1'b1, 8'd0, lat, pulses);
        vectors++;
        if (lat !== 1 || pulses !== 0) begin
            $display("FAIL zero_timing: lat/pulses got %0d/%0d want 1/0", lat, pulses);
            miscompares++;
        end
        vectors++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL zero_flags: err/busy got %b/%b want 0/0", err, busy);
            miscompares++;
        end
        for (int n = 0; n < 4; n++) begin
            vectors++;
            if (pos[POS_W*n +: POS_W] !== pos_exp(n)) begin
                $display("FAIL zero_pos%0d: got %0d want %0d", n, pos[POS_W*n +: POS_W],
                         pos_exp(n));
                miscompares++;
            end
        end
    endtask

    // Lock drops just before the second rise so lk falls while that pulse is high.
    task automatic test_lock_loss();
        int lat;
        int pulses;
        logic exp_step;
        req_sel = 2'd3;
        req_dir = 1'b0;
        req_count = 8'd5;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            exp_step = (k == 3 || k == 4 || k == 9 || k == 10);
            vectors++;
            if (phasestep !== exp_step) begin
                $display("FAIL abort_step: offset %0d got %b want %b", k, phasestep, exp_step);
                miscompares++;
            end
            vectors++;
            if (done !== (k == 11) || err !== (k >= 11) || busy !== (k <= 11)) begin
                $display("FAIL abort_flags: offset %0d done/err/busy got %b/%b/%b want %b/%b/%b",
                         k, done, err, busy, k == 11, k >= 11, k <= 11);
                miscompares++;
            end
            if (k == 8) pll_locked = 1'b0;
            tick();
        end
        exp_pos[3] = 1;
        vectors++;
        if (pos[POS_W*3 +: POS_W] !== pos_exp(3) || req_ready !== 1'b0) begin
            $display("FAIL abort_pos3_ready: pos3/ready got %0d/%b want %0d/0",
                     pos[POS_W*3 +: POS_W], req_ready, pos_exp(3));
            miscompares++;
        end
        pll_locked = 1'b1;
        tick();
        tick();
        do_request(2'd0, 1'b0, 8'd0, lat, pulses);
        vectors++;
        if (lat !== 1 || err !== 1'b0) begin
            $display("FAIL abort_err_clear: lat/err got %0d/%b want 1/0", lat, err);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid_pulse();
        int w;
        req_sel = 2'd0;
        req_dir = 1'b1;
        req_count = 8'd2;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        w = 0;
        while (phasestep !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        vectors++;
        if (phasestep !== 1'b1) begin
            $display("FAIL midreset_pulse_seen: got %b want 1", phasestep);
            miscompares++;
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({phasestep, busy, done, err, phasesel, phasedir, req_ready} !== 8'b0) begin
            $display("FAIL midreset_outputs: got %b want 0",
                     {phasestep, busy, done, err, phasesel, phasedir, req_ready});
            miscompares++;
        end
        exp_pos = '{0, 0, 0, 0};
        vectors++;
        if (pos !== '0) begin
            $display("FAIL midreset_pos: got %h want 0", pos);
            miscompares++;
        end
        tick();
        reset = 1'b0;
        tick();
        tick();
        vectors++;
        if (req_ready !== 1'b1 || phasestep !== 1'b0) begin
            $display("FAIL midreset_recover: ready/step got %b/%b want 1/0", req_ready,
                     phasestep);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_lock_handshake();
        test_basic_sequence();
        test_wrap();
        test_zero_count();
        test_lock_loss();
        test_reset_mid_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
